// File: rtl/latency_fifo_pkg.sv
// latency_fifo_pkg
// Shared defaults and the per-cycle operation encoding used by latency_fifo.
// The default COUNT_WIDTH matches the upstream free-running timer whose
// count_out drives cur_time.
package latency_fifo_pkg;

    localparam int unsigned LF_DATA_WIDTH_DEF  = 64;
    localparam int unsigned LF_DEPTH_BASE2_DEF = 4;
    localparam int unsigned LF_COUNT_WIDTH_DEF = 32;

    // What the FIFO does on a given edge: {pop, push}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/latency_fifo_mem.sv
// latency_fifo_mem
// Simple dual-port storage for the latency FIFO: registered write,
// asynchronous read. Each word holds {stamp, data}. Contents are not reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe (already qualified by the controller)
//   wr_addr  - write address
//   wr_data  - word to store
//   rd_addr  - read address (head pointer)
//   rd_data  - word at rd_addr, combinational
module latency_fifo_mem #(
    parameter int WIDTH      = 96,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port; no reset so the array maps onto plain RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/latency_fifo.sv
// latency_fifo
// First-word-fall-through FIFO whose head is only presented once it has been
// resident for at least `delay` time units of cur_time. Each entry is stamped
// with cur_time when written; age is the modular difference to the current
// time, so counter wrap-around is harmless. Only the head is ever examined,
// so entries always leave in write order.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   cur_time  - current time from the upstream free-running counter
//   delay     - minimum residency, applied to the head immediately
//   wr_en/din - write request and payload (dropped when full)
//   rd_en     - pop request, honoured only while valid=1
//   dout      - head payload (don't-care while empty)
//   valid     - head present and its delay expired
//   empty/full/count - registered occupancy
//   overflow  - sticky: some write was dropped
module latency_fifo
    import latency_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = LF_DATA_WIDTH_DEF,
    parameter int DEPTH_BASE2 = LF_DEPTH_BASE2_DEF,
    parameter int COUNT_WIDTH = LF_COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] cur_time,
    input  logic [COUNT_WIDTH-1:0] delay,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   valid,
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_BASE2:0]   count,
    output logic                   overflow
);

    localparam int WORD_WIDTH = COUNT_WIDTH + DATA_WIDTH;
    localparam logic [DEPTH_BASE2:0]   CNT_ZERO = (DEPTH_BASE2+1)'(0);
    localparam logic [DEPTH_BASE2:0]   CNT_ONE  = (DEPTH_BASE2+1)'(1);
    localparam logic [DEPTH_BASE2:0]   CNT_FULL = (DEPTH_BASE2+1)'(1 << DEPTH_BASE2);
    localparam logic [DEPTH_BASE2-1:0] PTR_ONE  = DEPTH_BASE2'(1);

    logic [DEPTH_BASE2-1:0] wr_ptr_r;
    logic [DEPTH_BASE2-1:0] rd_ptr_r;
    logic [DEPTH_BASE2:0]   count_r;
    logic                   empty_r;
    logic                   full_r;
    logic                   overflow_r;

    logic [WORD_WIDTH-1:0]  head_s;
    logic [COUNT_WIDTH-1:0] head_stamp_s;
    logic [COUNT_WIDTH-1:0] age_s;
    logic                   valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   mem_we_s;
    logic [DEPTH_BASE2:0]   count_nxt_s;
    fifo_op_e               op_s;

    latency_fifo_mem #(
        .WIDTH      (WORD_WIDTH),
        .ADDR_WIDTH (DEPTH_BASE2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({cur_time, din}),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Head qualification, push/pop decode and next occupancy
    always_comb begin
        head_stamp_s = head_s[WORD_WIDTH-1:DATA_WIDTH];
        // Unsigned subtraction wraps modulo 2^COUNT_WIDTH, covering cur_time roll-over
        age_s        = cur_time - head_stamp_s;
        valid_s      = !empty_r && (age_s >= delay);
        // A full FIFO drops the write even if a pop frees a slot this cycle
        push_s       = wr_en && !full_r;
        drop_s       = wr_en && full_r;
        pop_s        = rd_en && valid_s;
        mem_we_s     = push_s && !rst;
        op_s         = fifo_op_e'({pop_s, push_s});
        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CNT_ONE;
            OP_POP:  count_nxt_s = count_r - CNT_ONE;
            OP_BOTH: count_nxt_s = count_r;
            OP_IDLE: count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= CNT_ZERO;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_ZERO);
            full_r  <= (count_nxt_s == CNT_FULL);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign dout     = head_s[DATA_WIDTH-1:0];
    assign valid    = valid_s;
    assign empty    = empty_r;
    assign full     = full_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_latency_fifo.sv
// tb_latency_fifo
// Directed bench for latency_fifo: a table of single-cycle vectors for the
// delay / wrap / delay-change behaviour, then hand-written sequences for
// full/overflow, ordering and reset mid-flight.
// Cycle shape: inputs driven 1 time unit after a rising edge, outputs
// compared 4 units later (mid-cycle), state then advances on the next edge.
module tb_latency_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] cur_time;
    logic [31:0] delay;
    logic        wr_en;
    logic [63:0] din;
    logic        rd_en;
    logic [63:0] dout;
    logic        valid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;

    int checks;
    int failures;

    latency_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .cur_time (cur_time),
        .delay    (delay),
        .wr_en    (wr_en),
        .din      (din),
        .rd_en    (rd_en),
        .dout     (dout),
        .valid    (valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] ct;
        logic [31:0] dl;
        logic        wr;
        logic [63:0] d;
        logic        rd;
        logic        e_valid;
        logic        e_empty;
        logic [4:0]  e_count;
        logic        chk_dout;
        logic [63:0] e_dout;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs and wait to mid-cycle
    task automatic apply(input logic w, input logic [63:0] d, input logic r,
                         input logic [31:0] ct, input logic [31:0] dl);
        wr_en    = w;
        din      = d;
        rd_en    = r;
        cur_time = ct;
        delay    = dl;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = 64'h0;
        cur_time = 32'h0;
        delay    = 32'h0;

        // ct, delay, wr, din, rd, valid, empty, count, chk_dout, dout
        vecs[0]  = '{32'd10, 32'd5, 1'b1, 64'hA5, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[1]  = '{32'd11, 32'd5, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'hA5};
        vecs[2]  = '{32'd12, 32'd5, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'hA5};
        vecs[3]  = '{32'd13, 32'd5, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'hA5};
        vecs[4]  = '{32'd14, 32'd5, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 64'hA5};
        vecs[5]  = '{32'd15, 32'd5, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 64'hA5};
        vecs[6]  = '{32'd16, 32'd5, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[7]  = '{32'd20, 32'd5, 1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[8]  = '{32'd21, 32'd5, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'h11};
        vecs[9]  = '{32'd22, 32'd1, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 64'h11};
        vecs[10] = '{32'd23, 32'd0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[11] = '{32'd30, 32'd0, 1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[12] = '{32'd30, 32'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 64'h22};
        vecs[13] = '{32'd31, 32'd0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[14] = '{32'hFFFFFFFE, 32'd3, 1'b1, 64'h33, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};
        vecs[15] = '{32'hFFFFFFFF, 32'd3, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'h33};
        vecs[16] = '{32'h00000000, 32'd3, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 64'h33};
        vecs[17] = '{32'h00000001, 32'd3, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 64'h33};
        vecs[18] = '{32'h00000002, 32'd3, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 64'h0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        apply(1'b0, 64'h0, 1'b0, 32'd0, 32'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        tick();

        // Table: basic delay, idle pop, delay change, delay 0, wrap-around
        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].ct, vecs[i].dl);
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_empty));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
            chk($sformatf("vec%0d_full", i), 64'(full), 64'd0);
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'd0);
            if (vecs[i].chk_dout) begin
                chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
            end
            tick();
        end

        // Fill to 16 entries with delay 0 at a fixed time
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 64'h100 + 64'(i), 1'b0, 32'd100, 32'd0);
            tick();
        end
        apply(1'b1, 64'hDEAD, 1'b1, 32'd100, 32'd0);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_count", 64'(count), 64'd16);
        chk("full_valid", 64'(valid), 64'd1);
        chk("full_head", dout, 64'h100);
        tick();
        // Write dropped, head popped
        apply(1'b1, 64'h200, 1'b1, 32'd100, 32'd0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd15);
        chk("ovf_full", 64'(full), 64'd0);
        chk("ovf_head", dout, 64'h101);
        tick();
        // Simultaneous write and pop keeps count
        apply(1'b0, 64'h0, 1'b0, 32'd100, 32'd0);
        chk("both_count", 64'(count), 64'd15);
        chk("both_head", dout, 64'h102);
        // Drain: 0x102..0x10F then 0x200; the dropped 0xDEAD must not appear
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 64'h0, 1'b1, 32'd100, 32'd0);
            chk($sformatf("drain%0d", i), dout, (i < 14) ? (64'h102 + 64'(i)) : 64'h200);
            tick();
        end
        apply(1'b0, 64'h0, 1'b0, 32'd100, 32'd0);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        tick();

        // Ordering: A at t=0, B at t=1, delay 4; delay drops to 1 at t=3
        apply(1'b1, 64'hA, 1'b0, 32'd0, 32'd4);
        tick();
        apply(1'b1, 64'hB, 1'b0, 32'd1, 32'd4);
        tick();
        apply(1'b0, 64'h0, 1'b0, 32'd2, 32'd4);
        chk("ord_t2_valid", 64'(valid), 64'd0);
        tick();
        apply(1'b0, 64'h0, 1'b0, 32'd3, 32'd1);
        chk("ord_t3_valid", 64'(valid), 64'd1);
        chk("ord_t3_dout", dout, 64'hA);
        tick();
        apply(1'b0, 64'h0, 1'b1, 32'd4, 32'd1);
        chk("ord_t4_dout", dout, 64'hA);
        tick();
        apply(1'b0, 64'h0, 1'b1, 32'd5, 32'd1);
        chk("ord_t5_valid", 64'(valid), 64'd1);
        chk("ord_t5_dout", dout, 64'hB);
        tick();
        apply(1'b0, 64'h0, 1'b0, 32'd6, 32'd1);
        chk("ord_empty", 64'(empty), 64'd1);
        tick();

        // Reset mid-flight with 8 entries and wr_en held
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 64'h300 + 64'(i), 1'b0, 32'd50, 32'd0);
            tick();
        end
        rst = 1'b1;
        apply(1'b1, 64'h3FF, 1'b0, 32'd50, 32'd0);
        chk("pre_rst_count", 64'(count), 64'd8);
        tick();
        rst = 1'b0;
        apply(1'b0, 64'h0, 1'b1, 32'd60, 32'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        tick();
        // Idle pop on empty leaves state alone
        apply(1'b0, 64'h0, 1'b0, 32'd61, 32'd0);
        chk("idle_pop_count", 64'(count), 64'd0);
        chk("idle_pop_empty", 64'(empty), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latency_fifo.md
LATENCY_FIFO -- requirements
Module: latency_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, payload width in bits.
REQ-002 Parameter DEPTH_BASE2, default 4, log2 of entry count (16 entries).
REQ-003 Parameter COUNT_WIDTH, default 32, timestamp and delay width; matches the timer counter feeding cur_time.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cur_time  in  COUNT_WIDTH  current time from the upstream free-running counter's count_out.
REQ-008 delay  in  COUNT_WIDTH  minimum residency in time units, sampled every cycle.
REQ-009 wr_en  in  1  write request.
REQ-010 din  in  DATA_WIDTH  write payload.
REQ-011 rd_en  in  1  pop request.
REQ-012 dout  out  DATA_WIDTH  head payload, first-word-fall-through.
REQ-013 valid  out  1  head present and its delay has expired.
REQ-014 empty  out  1  no entries stored.
REQ-015 full  out  1  2^DEPTH_BASE2 entries stored.
REQ-016 count  out  DEPTH_BASE2+1  number of stored entries.
REQ-017 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-018 An accepted write SHALL store din together with cur_time, sampled on the same edge, as the entry's stamp.
REQ-019 A write with full=1 SHALL be dropped and SHALL set overflow, even if rd_en pops in the same cycle.
REQ-020 Age SHALL be computed as (cur_time - head_stamp) modulo 2^COUNT_WIDTH, so cur_time wrap-around is handled.
REQ-021 valid SHALL equal !empty && (age >= delay), combinational from registered state and the current inputs.
REQ-022 Behaviour is defined only for delay < 2^(COUNT_WIDTH-1).
REQ-023 An entry SHALL be visible no earlier than the cycle after its write; with delay=0, valid rises in cycle T+1 for a write in cycle T.
REQ-024 With cur_time incrementing by 1 per cycle and delay=D>=1, valid for a head written in cycle T SHALL first assert in cycle T+D.
REQ-025 rd_en with valid=1 SHALL pop the head; dout, valid and the head stamp SHALL reflect the next entry in the following cycle.
REQ-026 rd_en with valid=0 SHALL be ignored, with no state change and no error flag.
REQ-027 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-028 Only the head is considered: entries leave strictly in write order, even if a later entry's delay expired first.
REQ-029 Pointers SHALL be DEPTH_BASE2 bits and wrap modulo depth.
REQ-030 count, empty and full SHALL be registered and derived from count.
REQ-031 dout SHALL hold the head payload whenever empty=0; its value is don't-care when empty=1.
REQ-032 A change of delay SHALL apply to the head immediately, in the same cycle.

Reset
REQ-033 rst=1 SHALL clear both pointers, count and overflow, giving empty=1, full=0 and valid=0 on the cycle after the reset edge.
REQ-034 Reset mid-operation SHALL discard all stored entries; wr_en and rd_en asserted while rst=1 are ignored.
REQ-035 The storage array SHALL NOT be reset.

Structure
REQ-036 No shared package typedefs are required; default parameter values SHALL match the counter block's COUNT_WIDTH.
REQ-037 Storage SHALL be a separate sub-module, latency_fifo_mem: simple dual-port, registered write, asynchronous read at the head address, {stamp, data} wide.
REQ-038 All pointer, count and flag logic SHALL reside in latency_fifo.

Verification
REQ-039 Basic delay: delay=5, cur_time free-running from 0, write 0xA5 at cycle 10 -> valid=0 cycles 11-14, valid=1 and dout=0xA5 at cycle 15; rd_en at 15 -> empty=1 at 16.
REQ-040 Wrap-around: cur_time=0xFFFFFFFE at write, delay=3 -> valid asserts when cur_time=0x00000001, not held off by the wrap.
REQ-041 Full/overflow: 16 writes with no reads -> full=1 and count=16; 17th write with rd_en=1 and valid=1 -> write dropped, overflow=1, count=15.
REQ-042 Ordering: delay=4, write A at t=0 and B at t=1; at t=3 set delay=1 -> A valid, B not presented until A is popped; pop A -> dout=B with valid=1 next cycle.
REQ-043 Reset mid-flight: 8 entries stored, rst=1 for one cycle with wr_en=1 -> count=0, empty=1, valid=0, overflow=0 afterwards.
REQ-044 Idle pop: rd_en=1 while empty=1 or the head is not yet valid -> no pointer or count change.
